// File: rtl/plab2_mem_reqrespresponder.sv
// Val/rdy memory responder: word-addressed array, fixed-latency delay line and an
// in-order response FIFO whose occupancy bounds how many requests are accepted.
module plab2_mem_reqrespresponder #(
  parameter int p_mem_nbytes = 1024,
  parameter int p_latency    = 1,
  parameter int p_depth      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_val,
  output logic        req_rdy,
  input  logic        req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        resp_val,
  input  logic        resp_rdy,
  output logic        resp_type,
  output logic [31:0] resp_data
);
  localparam int AW     = $clog2(p_mem_nbytes);
  localparam int NW     = p_mem_nbytes / 4;
  localparam int IW     = AW - 2;
  localparam int STAGES = p_latency - 1;
  localparam int PW     = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int CW     = $clog2(p_depth + 1);

  typedef struct packed {
    logic        typ;
    logic [31:0] data;
  } resp_t;

  logic [31:0]   mem [NW];
  logic [IW-1:0] idx;
  logic          req_fire, resp_fire;
  logic [CW-1:0] outstanding;
  resp_t         req_pay, enq_pay, head;
  logic          enq_vld;

  logic unused_addr;
  assign unused_addr = ^{req_addr[31:AW], req_addr[1:0]};

  assign idx       = req_addr[AW-1:2];
  // Outstanding is registered, so resp_rdy never reaches req_rdy combinationally.
  assign req_rdy   = !reset && (outstanding < CW'(p_depth));
  assign req_fire  = req_val && req_rdy;
  assign resp_fire = resp_val && resp_rdy;

  always_ff @(posedge clk)
    if (req_fire && req_type) mem[idx] <= req_data;

  always_comb begin
    req_pay.typ  = req_type;
    req_pay.data = req_type ? 32'h0 : mem[idx];
  end

  // Delay line: shifts every cycle, the FIFO absorbs any backpressure.
  if (STAGES == 0) begin : g_nodl
    assign enq_vld = req_fire;
    assign enq_pay = req_pay;
  end else begin : g_dl
    logic [STAGES:1] vld_pipe;
    resp_t           pay_pipe [STAGES:1];

    always_ff @(posedge clk or posedge reset)
      if (reset) vld_pipe <= '0;
      else begin
        vld_pipe[1] <= req_fire;
        for (int i = 2; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
      end

    always_ff @(posedge clk) begin
      pay_pipe[1] <= req_pay;
      for (int i = 2; i <= STAGES; i++) pay_pipe[i] <= pay_pipe[i-1];
    end

    assign enq_vld = vld_pipe[STAGES];
    assign enq_pay = pay_pipe[STAGES];
  end

  resp_t         fifo [p_depth];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] fcnt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(p_depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk)
    if (enq_vld) fifo[wptr] <= enq_pay;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wptr        <= '0;
      rptr        <= '0;
      fcnt        <= '0;
      outstanding <= '0;
    end else begin
      if (enq_vld)   wptr <= ptr_inc(wptr);
      if (resp_fire) rptr <= ptr_inc(rptr);
      fcnt        <= fcnt + CW'(enq_vld) - CW'(resp_fire);
      outstanding <= outstanding + CW'(req_fire) - CW'(resp_fire);
    end

  assign head      = fifo[rptr];
  assign resp_val  = (fcnt != '0);
  assign resp_type = resp_val && head.typ;
  assign resp_data = resp_val ? head.data : 32'h0;

  // The outstanding limit already covers everything in the delay line plus FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(enq_vld && fcnt == CW'(p_depth)));
endmodule
